// File: rtl/issue_buffer_pkg.sv
// Instruction field layout, opcode constants and opcode classes shared by the
// issue buffer and its predecoder.
package issue_buffer_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int REG_RS_MSB = 25;
    localparam int REG_RS_LSB = 21;
    localparam int REG_RT_MSB = 20;
    localparam int REG_RT_LSB = 16;
    localparam int REG_RD_MSB = 15;
    localparam int REG_RD_LSB = 11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_ALUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } op_class_e;

    function automatic op_class_e op_class(input logic [5:0] opcode);
        op_class_e cls;
        case (opcode)
            OP_RTYPE: cls = CLS_RTYPE;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls = CLS_ALUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls = CLS_LOAD;
            OP_SB, OP_SH, OP_SW: cls = CLS_STORE;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
            OP_J, OP_JAL: cls = CLS_JUMP;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/issue_buffer_predecode.sv
// Combinational predecoder: maps the upper instruction fields of one candidate
// lane to its source/destination registers and hazard-relevant class flags.
module issue_predecode
    import issue_buffer_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [OPCODE_MSB-REG_RD_LSB:0] inst_hi_i,
    output logic [REG_W-1:0]               rs_o,
    output logic [REG_W-1:0]               rt_o,
    output logic [REG_W-1:0]               dst_o,
    output logic                           writes_o,
    output logic                           is_mem_o,
    output logic                           is_ctrl_o
);

    // Only opcode/rs/rt/rd affect grouping, so the shamt/funct/immediate low
    // bits are not routed here.
    localparam int BASE = REG_RD_LSB;

    op_class_e cls;

    always_comb begin
        cls       = op_class(inst_hi_i[OPCODE_MSB-BASE:OPCODE_LSB-BASE]);
        rs_o      = REG_W'(inst_hi_i[REG_RS_MSB-BASE:REG_RS_LSB-BASE]);
        rt_o      = REG_W'(inst_hi_i[REG_RT_MSB-BASE:REG_RT_LSB-BASE]);
        dst_o     = '0;
        writes_o  = 1'b0;
        is_mem_o  = 1'b0;
        is_ctrl_o = 1'b0;
        case (cls)
            CLS_RTYPE: begin
                writes_o = 1'b1;
                dst_o    = REG_W'(inst_hi_i[REG_RD_MSB-BASE:REG_RD_LSB-BASE]);
            end
            CLS_ALUI: begin
                writes_o = 1'b1;
                dst_o    = rt_o;
            end
            CLS_LOAD: begin
                writes_o = 1'b1;
                dst_o    = rt_o;
                is_mem_o = 1'b1;
            end
            CLS_STORE:  is_mem_o  = 1'b1;
            CLS_BRANCH: is_ctrl_o = 1'b1;
            CLS_JUMP:   is_ctrl_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/issue_buffer.sv
// In-order fetch buffer and issue-group former: a circular queue filled by
// fetch bundles, drained each cycle by the longest hazard-free head prefix.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int INST_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int FETCH_WIDTH        = 2,
    parameter int ISSUE_WIDTH        = 2,
    parameter int DEPTH              = 8,
    parameter int NUM_REGISTERS_LOG2 = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              fetch_valid,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] fetch_inst,
    input  logic [ADDR_WIDTH-1:0]             fetch_pc,
    input  logic [$clog2(FETCH_WIDTH):0]      fetch_count,
    output logic                              fetch_ready,
    input  logic                              flush,
    input  logic                              stall,
    output logic [ISSUE_WIDTH-1:0]            issue_valid,
    output logic [ISSUE_WIDTH*INST_WIDTH-1:0] issue_inst,
    output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] issue_pc,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(FETCH_WIDTH) + 1;
    localparam int GS_W  = $clog2(ISSUE_WIDTH) + 1;
    localparam int REG_W = NUM_REGISTERS_LOG2;

    // Handshake: a bundle transfers on a rising edge where fetch_valid &&
    // fetch_ready && !flush; fetch_ready depends only on registered occupancy,
    // so a fetcher seeing ready low must hold its bundle until ready returns.

    logic [INST_WIDTH-1:0]            inst_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]            pc_mem_q   [DEPTH];
    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [ISSUE_WIDTH-1:0]           issue_valid_q, issue_valid_d;
    logic [ISSUE_WIDTH*INST_WIDTH-1:0] issue_inst_q, issue_inst_d;
    logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;

    logic                             enq_fire;
    logic [FC_W-1:0]                  enq_n;
    logic [GS_W-1:0]                  grp_size;
    logic [GS_W-1:0]                  deq_n;
    logic [ISSUE_WIDTH-1:0]           grp_join;
    logic                             grp_open;
    logic                             lane_ok;

    logic [PTR_W-1:0]                 wr_idx    [FETCH_WIDTH];
    logic [PTR_W-1:0]                 rd_idx    [ISSUE_WIDTH];
    logic [INST_WIDTH-1:0]            cand_inst [ISSUE_WIDTH];
    logic [ADDR_WIDTH-1:0]            cand_pc   [ISSUE_WIDTH];

    logic [REG_W-1:0]                 pd_rs     [ISSUE_WIDTH];
    logic [REG_W-1:0]                 pd_rt     [ISSUE_WIDTH];
    logic [REG_W-1:0]                 pd_dst    [ISSUE_WIDTH];
    logic                             pd_writes [ISSUE_WIDTH];
    logic                             pd_mem    [ISSUE_WIDTH];
    logic                             pd_ctrl   [ISSUE_WIDTH];

    assign fetch_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
    assign enq_fire    = fetch_valid && fetch_ready && !flush;
    assign enq_n       = enq_fire ? fetch_count : '0;
    assign deq_n       = (flush || stall) ? '0 : grp_size;

    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            wr_idx[k] = tail_q + PTR_W'(k);
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_idx[k]    = head_q + PTR_W'(k);
            cand_inst[k] = inst_mem_q[rd_idx[k]];
            cand_pc[k]   = pc_mem_q[rd_idx[k]];
        end
    end

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_pd
        issue_predecode #(
            .REG_W(REG_W)
        ) u_predecode (
            .inst_hi_i(cand_inst[k][OPCODE_MSB:REG_RD_LSB]),
            .rs_o     (pd_rs[k]),
            .rt_o     (pd_rt[k]),
            .dst_o    (pd_dst[k]),
            .writes_o (pd_writes[k]),
            .is_mem_o (pd_mem[k]),
            .is_ctrl_o(pd_ctrl[k])
        );
    end

    // A lane joins only if every older lane joined; the first rejection closes
    // the group, which keeps issue strictly in order.
    always_comb begin
        grp_join = '0;
        grp_size = '0;
        grp_open = 1'b1;
        lane_ok  = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane_ok = grp_open && (CNT_W'(k) < count_q);
            if (k > 0) begin
                if (pd_mem[k]) begin
                    lane_ok = 1'b0;
                end
                for (int j = 0; j < k; j++) begin
                    if (pd_ctrl[j]) begin
                        lane_ok = 1'b0;
                    end
                    if (pd_writes[j] && (pd_dst[j] != '0)) begin
                        if ((pd_rs[k] == pd_dst[j]) || (pd_rt[k] == pd_dst[j])) begin
                            lane_ok = 1'b0;
                        end
                        if (pd_writes[k] && (pd_dst[k] == pd_dst[j])) begin
                            lane_ok = 1'b0;
                        end
                    end
                end
            end
            grp_join[k] = lane_ok;
            if (lane_ok) begin
                grp_size = grp_size + GS_W'(1);
            end else begin
                grp_open = 1'b0;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_inst_d  = issue_inst_q;
        issue_pc_d    = issue_pc_q;
        if (flush) begin
            issue_valid_d = '0;
        end else if (!stall) begin
            issue_valid_d = grp_join;
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                issue_inst_d[k*INST_WIDTH +: INST_WIDTH] = cand_inst[k];
                issue_pc_d[k*ADDR_WIDTH +: ADDR_WIDTH]   = cand_pc[k];
            end
        end
    end

    // Queue storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (FC_W'(k) < fetch_count) begin
                    inst_mem_q[wr_idx[k]] <= fetch_inst[k*INST_WIDTH +: INST_WIDTH];
                    pc_mem_q[wr_idx[k]]   <= fetch_pc + ADDR_WIDTH'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            issue_valid_q <= '0;
            issue_inst_q  <= '0;
            issue_pc_q    <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_inst_q  <= issue_inst_d;
            issue_pc_q    <= issue_pc_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_inst  = issue_inst_q;
    assign issue_pc    = issue_pc_q;
    assign count       = count_q;

endmodule

// File: tb/tb_issue_buffer.sv
// Bench for issue_buffer: directed and random fetch traffic against a queue
// model of the grouping rules, with a per-cycle expectation scoreboard.
module tb_issue_buffer;

    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [15:0] pc;
    } ent_t;

    typedef struct packed {
        logic [IW-1:0]    valid;
        logic [IW*32-1:0] inst;
        logic [IW*16-1:0] pc;
        logic [3:0]       cnt;
        logic             rdy;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             fetch_valid = 1'b0;
    logic [FW*32-1:0] fetch_inst = '0;
    logic [15:0]      fetch_pc = '0;
    logic [1:0]       fetch_count = '0;
    logic             fetch_ready;
    logic             flush = 1'b0;
    logic             stall = 1'b0;
    logic [IW-1:0]    issue_valid;
    logic [IW*32-1:0] issue_inst;
    logic [IW*16-1:0] issue_pc;
    logic [3:0]       count;

    logic [EXP_W-1:0] exp_q[$];
    ent_t             mq[$];
    logic [IW-1:0]    mv = '0;
    logic [IW*32-1:0] minst = '0;
    logic [IW*16-1:0] mpc = '0;
    int               n_vec = 0;
    int               n_err = 0;

    issue_buffer #(
        .INST_WIDTH(32), .ADDR_WIDTH(16), .FETCH_WIDTH(FW),
        .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .NUM_REGISTERS_LOG2(5)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
        .fetch_count(fetch_count), .fetch_ready(fetch_ready),
        .flush(flush), .stall(stall),
        .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_pc(issue_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_op(input int rd, input int rs, input int rt, input logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic int rr();
        return int'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        case ($urandom_range(0, 7))
            0, 1, 2: return r_op(rr(), rr(), rr(), 6'h20);
            3:       return i_op(6'h08, rr(), rr(), int'($urandom_range(0, 255)));
            4:       return i_op(6'h23, rr(), rr(), 4);
            5:       return i_op(6'h2b, rr(), rr(), 8);
            6:       return i_op(6'h04, rr(), rr(), 2);
            default: return {6'h02, 26'($urandom)};
        endcase
    endfunction

    // Reference decode for the opcodes this bench generates.
    function automatic void tb_decode(input logic [31:0] i, output bit wr, output logic [4:0] dst,
                                      output bit mem, output bit ctl);
        wr = 0; dst = 5'd0; mem = 0; ctl = 0;
        case (i[31:26])
            6'h00: begin wr = 1; dst = i[15:11]; end
            6'h08: begin wr = 1; dst = i[20:16]; end
            6'h23: begin wr = 1; dst = i[20:16]; mem = 1; end
            6'h2b: mem = 1;
            6'h04, 6'h02: ctl = 1;
            default: ;
        endcase
    endfunction

    function automatic int tb_group_size();
        int  n;
        bit  wk, wj, mk, mj, ck, cj, bad;
        logic [4:0] dk, dj;
        n = 0;
        for (int k = 0; k < IW && k < mq.size(); k++) begin
            if (k > 0) begin
                tb_decode(mq[k].inst, wk, dk, mk, ck);
                bad = mk;
                for (int j = 0; j < k; j++) begin
                    tb_decode(mq[j].inst, wj, dj, mj, cj);
                    if (cj) bad = 1;
                    if (wj && dj != 0) begin
                        if (mq[k].inst[25:21] == dj || mq[k].inst[20:16] == dj) bad = 1;
                        if (wk && dk == dj) bad = 1;
                    end
                end
                if (bad) break;
            end
            n++;
        end
        return n;
    endfunction

    // Drive one cycle of stimulus and record what the DUT must show after the edge.
    task automatic drive_cycle(input bit fv, input logic [FW*32-1:0] fi, input logic [15:0] fp,
                               input int fc, input bit fl, input bit st, output bit acc);
        exp_t e;
        bit   rdy;
        int   n;
        @(negedge clk);
        fetch_valid = fv; fetch_inst = fi; fetch_pc = fp;
        fetch_count = 2'(fc); flush = fl; stall = st;
        rdy = (DEPTH - mq.size()) >= FW;
        acc = 0;
        if (fl) begin
            mq.delete();
            mv = '0;
        end else begin
            if (!st) begin
                n  = tb_group_size();
                mv = '0;
                for (int k = 0; k < n; k++) begin
                    mv[k] = 1'b1;
                    minst[k*32 +: 32] = mq[0].inst;
                    mpc[k*16 +: 16]   = mq[0].pc;
                    void'(mq.pop_front());
                end
            end
            if (fv && rdy) begin
                acc = 1;
                for (int s = 0; s < fc; s++) mq.push_back({fi[s*32 +: 32], fp + 16'(s)});
            end
        end
        e.valid = mv; e.inst = minst; e.pc = mpc;
        e.cnt = 4'(mq.size());
        e.rdy = (DEPTH - mq.size()) >= FW;
        exp_q.push_back(EXP_W'(e));
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive_cycle(0, '0, 16'h0, 1, 0, 0, a);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                chk("issue_valid", 64'(issue_valid), 64'(e.valid));
                for (int k = 0; k < IW; k++) begin
                    if (e.valid[k]) begin
                        chk($sformatf("lane%0d_inst", k), 64'(issue_inst[k*32 +: 32]), 64'(e.inst[k*32 +: 32]));
                        chk($sformatf("lane%0d_pc", k), 64'(issue_pc[k*16 +: 16]), 64'(e.pc[k*16 +: 16]));
                    end
                end
                chk("count", 64'(count), 64'(e.cnt));
                chk("fetch_ready", 64'(fetch_ready), 64'(e.rdy));
            end
        end
    end

    initial begin : stimulus
        bit          a;
        logic [15:0] rpc;
        bit          fv, fl, st;
        int          fc;

        #12;
        chk("rst_valid", 64'(issue_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_inst", 64'(issue_inst), 64'd0);
        chk("rst_pc", 64'(issue_pc), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Independent pair, then RAW pair, memory op in lane 1, branch closing a group.
        drive_cycle(1, {r_op(4, 5, 6, 6'h20), r_op(3, 1, 2, 6'h20)}, 16'h10, 2, 0, 0, a);
        idle(2);
        drive_cycle(1, {r_op(7, 3, 2, 6'h22), r_op(3, 1, 2, 6'h20)}, 16'h20, 2, 0, 0, a);
        idle(3);
        drive_cycle(1, {i_op(6'h23, 9, 8, 0), r_op(3, 1, 2, 6'h20)}, 16'h30, 2, 0, 0, a);
        idle(3);
        drive_cycle(1, {r_op(10, 11, 12, 6'h20), i_op(6'h04, 1, 2, 4)}, 16'h40, 2, 0, 0, a);
        idle(3);

        // Fill under stall, overflow attempt, then drain.
        for (int i = 0; i < 5; i++)
            drive_cycle(1, {i_op(6'h08, 0, 2*i+2, i), i_op(6'h08, 0, 2*i+1, i)}, 16'h50 + 16'(2*i), 2, 0, 1, a);
        idle(6);

        // Flush with a bundle presented in the same cycle.
        for (int i = 0; i < 3; i++)
            drive_cycle(1, {i_op(6'h08, 0, 2*i+2, i), i_op(6'h08, 0, 2*i+1, i)}, 16'h70 + 16'(2*i), 2, 0, 1, a);
        drive_cycle(1, {rand_inst(), rand_inst()}, 16'h80, 2, 1, 1, a);
        idle(2);

        // Build count=5 with a full issue group visible, then reset asynchronously.
        drive_cycle(1, {i_op(6'h08, 0, 2, 1), i_op(6'h08, 0, 1, 1)}, 16'h90, 2, 0, 0, a);
        drive_cycle(1, {i_op(6'h08, 0, 4, 1), i_op(6'h08, 0, 3, 1)}, 16'h92, 2, 0, 0, a);
        drive_cycle(1, {i_op(6'h08, 0, 6, 1), i_op(6'h08, 0, 5, 1)}, 16'h94, 2, 0, 1, a);
        drive_cycle(1, {i_op(6'h08, 0, 0, 1), i_op(6'h08, 0, 7, 1)}, 16'h96, 1, 0, 1, a);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(issue_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_ready", 64'(fetch_ready), 64'd1);
        chk("async_rst_inst", 64'(issue_inst), 64'd0);
        chk("async_rst_pc", 64'(issue_pc), 64'd0);
        fetch_valid = 0; flush = 0; stall = 0;
        mq.delete(); mv = '0; minst = '0; mpc = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Twenty instructions pushed through the eight-entry queue, with some stalls.
        for (int i = 0; i < 10; i++)
            drive_cycle(1, {i_op(6'h08, 0, 2, i), i_op(6'h08, 0, 1, i)}, 16'h100 + 16'(2*i), 2, 0,
                        (i % 3) == 2, a);
        idle(8);

        // Random traffic with hazards, stalls, short bundles and occasional flushes.
        rpc = 16'h200;
        for (int i = 0; i < 400; i++) begin
            fv = $urandom_range(0, 3) != 0;
            fc = int'($urandom_range(1, 2));
            st = $urandom_range(0, 3) == 0;
            fl = $urandom_range(0, 40) == 0;
            drive_cycle(fv, {rand_inst(), rand_inst()}, rpc, fc, fl, st, a);
            if (a) rpc = rpc + 16'(fc);
        end
        idle(10);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- Parametrised in-order fetch buffer and issue-group former for the multi-issue pipeline.
- Sits between instruction_memory and the decode/id_ex stage, replacing the fixed two-lane fetch path with one generalised in FETCH_WIDTH, ISSUE_WIDTH and DEPTH.
- Each cycle it accepts a fetch bundle into a circular queue, then issues the longest hazard-free in-order prefix of the queue head.
- Only lane 0 may carry a memory op, and control ops close a group.

Parameters:
INST_WIDTH, 32, instruction width in bits
ADDR_WIDTH, 16, instruction address width
FETCH_WIDTH, 2, instructions per fetch bundle (>=1)
ISSUE_WIDTH, 2, issue lanes (1..DEPTH)
DEPTH, 8, queue entries; power of 2, >= FETCH_WIDTH+ISSUE_WIDTH
NUM_REGISTERS_LOG2, 5, register specifier width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_valid  in  1  fetch bundle present
fetch_inst  in  FETCH_WIDTH*INST_WIDTH  bundle; slot 0 in LSBs, oldest
fetch_pc  in  ADDR_WIDTH  address of slot 0; slot k is at fetch_pc+k
fetch_count  in  $clog2(FETCH_WIDTH)+1  number of valid slots, 1..FETCH_WIDTH, starting at slot 0
fetch_ready  out  1  free entries >= FETCH_WIDTH
flush  in  1  discard all buffered and issued instructions
stall  in  1  downstream stall (hazard_detection_unit)
issue_valid  out  ISSUE_WIDTH  per-lane valid, contiguous from lane 0
issue_inst  out  ISSUE_WIDTH*INST_WIDTH  issued instructions; lane 0 in LSBs
issue_pc  out  ISSUE_WIDTH*ADDR_WIDTH  per-lane address
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - head and tail pointers and count to 0;
  - issue_valid, issue_inst and issue_pc to 0.
  - fetch_ready is 1 while in reset and afterwards.
- Enqueue:
  - Condition: edge with fetch_valid && fetch_ready && !flush.
  - Writes fetch_count slots at tail, each with its pc.
  - tail advances by fetch_count, mod DEPTH.
  - If fetch_valid is high while fetch_ready is low, the bundle is dropped; the fetcher must hold it.
- fetch_ready = (DEPTH - count) >= FETCH_WIDTH. It uses the registered count and does not credit the same-cycle dequeue.
- Group formation (combinational, from head): candidate k in 0..ISSUE_WIDTH-1 joins the group only if all of the following hold:
  - entry k exists (k < count);
  - all of 0..k-1 joined;
  - for k>0, the entry is not a memory op;
  - for k>0, no older entry j<k in the group is a control op (branch/jump);
  - for k>0, no RAW: rs_k and rt_k ≠ dst_j for any j<k with writes_j and dst_j≠0;
  - for k>0, no WAW: dst_k ≠ dst_j under the same conditions.
- Lane 0 is always eligible when count>0.
- Predecode:
  - opcode 0 (R-type) writes rd;
  - ALU-immediate and load ops write rt;
  - store, branch and jump write nothing.
  - Control ops are branches and jumps; memory ops are loads and stores.
- Issue register (1-cycle latency):
  - stall=1 and flush=0: issue outputs hold, head does not move, enqueue still allowed.
  - stall=0: issue outputs load the group. Lanes beyond the group size get valid=0, with inst/pc don't-care.
  - head advances by group size. count_next = count + enq - group_size.
  - Empty buffer gives issue_valid=0 (bubble).
- Flush has priority over stall and enqueue:
  - head=tail=count=0 and issue_valid=0 at the edge;
  - the same-cycle fetch bundle is discarded.
- Earliest issue of an instruction enqueued at edge N is edge N+1.
- Simultaneous enqueue and dequeue are legal at full occupancy boundaries; count never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- Writes at tail never overwrite unissued entries, which fetch_ready guarantees.

Decomposition:
- Shared defines (defines.vh) supply the following:
  - opcode field MSB/LSB, REG_RS/RT/RD MSB/LSB and opcode constants;
  - new class constants for load/store/branch/jump grouping.
- One sub-module: issue_predecode. It is combinational, instantiated per candidate lane, and maps an instruction to {rs, rt, dst, writes, is_mem, is_ctrl}.
- The queue, pointer arithmetic and group former stay in issue_buffer.

Test Plan:
- Reset then fetch {ADD r3=r1+r2 @0x10, ADD r4=r5+r6 @0x11}, stall=0: next edge issue_valid=2'b11, issue_pc={0x11,0x10}, count returns 0.
- Fetch {ADD r3=r1+r2, SUB r7=r3-r2}: RAW means cycle 1 issue_valid=2'b01 (ADD) and cycle 2 issue_valid=2'b01 (SUB in lane 0).
- Fetch {ADD, LW r8,0(r9)}: LW is not allowed in lane 1, so cycle 1 issues ADD only and cycle 2 issues LW in lane 0. Then {BEQ, ADD}: BEQ issues alone.
- Hold stall=1 with 4 fetches of 2 (DEPTH=8): count reaches 8 and fetch_ready drops to 0 with count=7 or 8; a further fetch is dropped and count stays 8. Issue outputs stay frozen throughout.
- With count=6 plus fetch_valid plus flush in the same cycle: next edge count=0, issue_valid=0, fetch_ready=1.
- Assert reset mid-stream with count=5 and issue_valid=2'b11: all outputs go to 0 immediately without waiting for clk. After release, the wrap-around test pushes 20 instructions through DEPTH=8 with pc order preserved.
